bitgen_sequencer: RTL



---
 rtl/bitseq_pkg.sv | 15 +
 rtl/bitseq_baud_div.sv | 27 ++
 rtl/bitgen_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bitseq_pkg.sv
// Shared types and constants for the bit-pattern sequencer.
package bitseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SEL_IDLE = 4'd0;

    // Bit i is the expected generator output for SEL code i+1.
    localparam logic [7:0] GOLDEN_PATTERN = 8'hB1;

endpackage

// File: rtl/bitseq_baud_div.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the terminal count.
module bitseq_baud_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tc
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (tc)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/bitgen_sequencer.sv
// Steps the generator SEL through 1..NUM_BITS and samples its bitstream once per bit.
// Optional golden-pattern checker enabled by BITSEQ_PATTERN_CHECK_EN (adds pattern_err).
module bitgen_sequencer
    import bitseq_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int NUM_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       abort,
    input  logic       bit_in,
    output logic [3:0] sel,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       busy,
    output logic       done
`ifdef BITSEQ_PATTERN_CHECK_EN
  , output logic       pattern_err
`endif
);

    localparam logic [3:0] LAST_SEL = 4'(NUM_BITS);

    state_t     state, state_nx;
    logic [3:0] sel_nx;
    logic       bit_out_nx, valid_nx;
    logic       cont_q, cont_nx;
    logic       tc, div_clear;

    // Divider is held at zero outside RUN and restarts on abort.
    assign div_clear = (state != RUN) || abort;

    bitseq_baud_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (div_clear),
        .tc    (tc)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef BITSEQ_PATTERN_CHECK_EN
    logic       err_nx;
    logic [2:0] gidx;
    assign gidx = 3'(sel - 4'd1);
`endif

    always_comb begin
        state_nx   = state;
        sel_nx     = sel;
        bit_out_nx = bit_out;
        valid_nx   = 1'b0;
        cont_nx    = cont_q;
`ifdef BITSEQ_PATTERN_CHECK_EN
        err_nx     = pattern_err;
`endif
        unique case (state)
            IDLE: begin
                sel_nx = SEL_IDLE;
                if (start && !abort) begin
                    state_nx = RUN;
                    sel_nx   = 4'd1;
                    cont_nx  = continuous;
`ifdef BITSEQ_PATTERN_CHECK_EN
                    err_nx   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                    sel_nx   = SEL_IDLE;
                end else if (tc) begin
                    bit_out_nx = bit_in;
                    valid_nx   = 1'b1;
`ifdef BITSEQ_PATTERN_CHECK_EN
                    if (bit_in != GOLDEN_PATTERN[gidx])
                        err_nx = 1'b1;
`endif
                    if (sel < LAST_SEL) begin
                        sel_nx = sel + 4'd1;
                    end else if (cont_q) begin
                        sel_nx = 4'd1;
                    end else begin
                        state_nx = DONE;
                        sel_nx   = SEL_IDLE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                sel_nx   = SEL_IDLE;
            end
            default: begin
                state_nx = IDLE;
                sel_nx   = SEL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= SEL_IDLE;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            cont_q    <= 1'b0;
`ifdef BITSEQ_PATTERN_CHECK_EN
            pattern_err <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            bit_out   <= bit_out_nx;
            bit_valid <= valid_nx;
            cont_q    <= cont_nx;
`ifdef BITSEQ_PATTERN_CHECK_EN
            pattern_err <= err_nx;
`endif
        end
    end

endmodule
